instr_exec: RTL and testbench
=============================

# instr_exec

Single-accumulator execution stage that consumes the 4-bit instruction words read out of the instruction RAM, one per program-counter step. It sits directly downstream of the instruction memory, at the clock-domain level of the system clock. It accepts an instruction through a valid/ready handshake, executes it in a fixed two-cycle sequence, and exposes the accumulator, flags, halt status and a retired-instruction count.

## Interface
- CNT_W, default 8: width of the retired-instruction counter.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instructions  input  4  instruction word from instruction RAM; sampled only on handshake.
- instr_valid  input  1  upstream asserts when `instructions` holds a new word.
- instr_ready  output  1  block can accept a word this cycle.
- acc  output  4  accumulator.
- carry  output  1  carry/borrow/shift-out flag.
- zero  output  1  registered `acc == 0`.
- halted  output  1  HALT executed; block frozen.
- retired  output  CNT_W  count of executed instructions, HALT included.

## Operation
- Opcode map, with ir = captured word and k = ir[1:0] zero-extended to 4 bits:
  - 00kk LDI: acc <= k; carry <= 0.
  - 01kk ADDI: {carry, acc} <= acc + k (5-bit sum).
  - 10kk SUBI: acc <= acc - k mod 16; carry <= 1 iff acc < k (borrow).
  - 1100 CLR: acc <= 0; carry <= 0.
  - 1101 NOT: acc <= ~acc; carry unchanged.
  - 1110 SHL: carry <= acc[3]; acc <= {acc[2:0], 1'b0}.
  - 1111 HALT: acc and carry unchanged; halted <= 1.
- zero is updated in the same cycle as acc, from the new acc value. It is updated for every executed opcode, including NOT and HALT.
- FSM states are IDLE, EXEC and STOP.
  - IDLE: instr_ready = 1. When instr_valid = 1: ir <= instructions, go to EXEC. Otherwise stay.
  - EXEC: instr_ready = 0. Apply the opcode and increment retired (wraps modulo 2^CNT_W). HALT goes to STOP; every other opcode goes to IDLE.
  - STOP: instr_ready = 0 and halted = 1 permanently. instr_valid is ignored. Only rst_n exits.
- Arithmetic is unsigned 4-bit. There are no other side effects.

## Timing
- Reset (async, while rst_n = 0): state IDLE, ir 0, acc 0, carry 0, zero 1, halted 0, retired 0, instr_ready 1.
- Handshake completes at edge N when instr_valid and instr_ready are both 1.
- Results (acc, carry, zero, retired, halted) are visible after edge N+1.
- instr_ready is low for exactly the cycle following acceptance.
- Peak throughput is one instruction per 2 cycles.
- instr_valid held high continuously: a new word is accepted every second edge. Upstream must present the next word by then or hold the current one. The block accepts whatever is on `instructions` at the sampling edge.
- instr_valid during EXEC: not consumed, no error.
- Reset mid-EXEC: the in-flight instruction is lost, all outputs return to reset values immediately, and retired does not count it.
- retired at max value: wraps to 0 on the next executed instruction.

## Structure
- Package `instr_pkg`:
  - opcode constants: OP_LDI = 2'b00, OP_ADDI = 2'b01, OP_SUBI = 2'b10, OP_MISC = 2'b11.
  - MISC sub-codes: CLR = 2'b00, NOT = 2'b01, SHL = 2'b10, HLT = 2'b11.
  - FSM state typedef.
- Sub-module `alu4`: purely combinational. Inputs are ir, acc and carry; outputs are next acc, next carry and an is_halt flag.
- `instr_exec` holds the FSM, ir, acc/carry/zero registers and the retired counter.

## Test plan
- Reset then hold idle: acc = 0, zero = 1, carry = 0, halted = 0, instr_ready = 1, retired = 0.
- Sequence LDI 3 (0011), ADDI 3 (0111), ADDI 3 -> acc 3, 6, 9 after respective EXEC edges; carry 0; retired = 3; instr_ready pattern 1,0,1,0,…
- LDI 0 then SUBI 1 (1001) -> acc = 15, carry = 1, zero = 0. Then ADDI 1 -> acc = 0, carry = 1, zero = 1.
- LDI 3, SHL, SHL, SHL -> acc 6, 12, 8; carry 0, 0, 1. Then NOT -> acc = 7, carry still 1. Then CLR -> acc = 0, carry = 0, zero = 1.
- HALT (1111) with instr_valid then held high and a word of LDI 2 presented:
  - halted = 1 one edge after acceptance;
  - instr_ready stays 0, acc unchanged, retired increments once only.
  - Then pulse rst_n low mid-cycle: all outputs return to reset values asynchronously.
- Force the counter near wrap using 300 ADDI 0 instructions with CNT_W = 8 -> retired = 44; acc unchanged; zero reflects acc.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcode constants and FSM state type for the accumulator execution stage.
package instr_pkg;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_SUBI = 2'b10;
    localparam logic [1:0] OP_MISC = 2'b11;

    localparam logic [1:0] CLR = 2'b00;
    localparam logic [1:0] NOT = 2'b01;
    localparam logic [1:0] SHL = 2'b10;
    localparam logic [1:0] HLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        STOP = 2'b10
    } state_t;

endpackage

// File: rtl/instr_exec_alu4.sv
// Combinational 4-bit accumulator ALU: next acc/carry for the captured word.
module alu4
    import instr_pkg::*;
(
    input  logic [3:0] ir,
    input  logic [3:0] acc,
    input  logic       carry,
    output logic [3:0] acc_nxt,
    output logic       carry_nxt,
    output logic       is_halt
);

    logic [3:0] k;
    logic [4:0] sum;
    logic [4:0] diff;

    assign k    = {2'b00, ir[1:0]};
    assign sum  = {1'b0, acc} + {1'b0, k};
    // Bit 4 of the 5-bit difference is the borrow (acc < k).
    assign diff = {1'b0, acc} - {1'b0, k};

    always_comb begin
        acc_nxt   = acc;
        carry_nxt = carry;
        is_halt   = 1'b0;
        unique case (ir[3:2])
            OP_LDI: begin
                acc_nxt   = k;
                carry_nxt = 1'b0;
            end
            OP_ADDI: begin
                acc_nxt   = sum[3:0];
                carry_nxt = sum[4];
            end
            OP_SUBI: begin
                acc_nxt   = diff[3:0];
                carry_nxt = diff[4];
            end
            OP_MISC: begin
                unique case (ir[1:0])
                    CLR: begin
                        acc_nxt   = 4'd0;
                        carry_nxt = 1'b0;
                    end
                    NOT: acc_nxt = ~acc;
                    SHL: begin
                        acc_nxt   = {acc[2:0], 1'b0};
                        carry_nxt = acc[3];
                    end
                    HLT: is_halt = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_exec.sv
// Single-accumulator execution stage: accept one word, execute it next cycle.
module instr_exec
    import instr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       instructions,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [3:0]       acc,
    output logic             carry,
    output logic             zero,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] ir;
    logic [3:0] acc_nxt;
    logic       carry_nxt;
    logic       is_halt;

    alu4 u_alu (
        .ir       (ir),
        .acc      (acc),
        .carry    (carry),
        .acc_nxt  (acc_nxt),
        .carry_nxt(carry_nxt),
        .is_halt  (is_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (instr_valid) state_nxt = EXEC;
            EXEC:    state_nxt = is_halt ? STOP : IDLE;
            STOP:    state_nxt = STOP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        halted      = 1'b0;
        unique case (state)
            IDLE:    instr_ready = 1'b1;
            STOP:    halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= 4'd0;
            acc     <= 4'd0;
            carry   <= 1'b0;
            zero    <= 1'b1;
            retired <= '0;
        end else begin
            if (state == IDLE && instr_valid) begin
                ir <= instructions;
            end
            if (state == EXEC) begin
                acc     <= acc_nxt;
                carry   <= carry_nxt;
                zero    <= (acc_nxt == 4'd0);
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_exec.sv
// Bench for instr_exec: vector table feeding a scoreboard, plus halt/reset/wrap sequences.
module tb_instr_exec;

    logic       clk;
    logic       rst_n;
    logic [3:0] instructions;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic       halted;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] instr;
        logic [3:0] acc;
        logic       carry;
    } vec_t;

    typedef struct {
        logic [3:0] acc;
        logic       carry;
        logic       zero;
        logic [7:0] ret;
        logic       halted;
    } exp_t;

    vec_t       vecs[18];
    exp_t       exp_q[$];
    logic [7:0] m_ret;

    instr_exec #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instructions(instructions),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acc         (acc),
        .carry       (carry),
        .zero        (zero),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " acc"}, 32'(acc), 32'd0);
        chk({tag, " carry"}, 32'(carry), 32'd0);
        chk({tag, " zero"}, 32'(zero), 32'd1);
        chk({tag, " halted"}, 32'(halted), 32'd0);
        chk({tag, " ready"}, 32'(instr_ready), 32'd1);
        chk({tag, " retired"}, 32'(retired), 32'd0);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, " acc"}, 32'(acc), 32'(e.acc));
        chk({tag, " carry"}, 32'(carry), 32'(e.carry));
        chk({tag, " zero"}, 32'(zero), 32'(e.zero));
        chk({tag, " retired"}, 32'(retired), 32'(e.ret));
        chk({tag, " halted"}, 32'(halted), 32'(e.halted));
    endtask

    // Drive one word from a negedge; valid stays high through EXEC.
    task automatic send(input logic [3:0] w, input logic [3:0] e_acc,
                        input logic e_carry, input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk({tag, " ready timeout"}, 32'(instr_ready), 32'd1);
            return;
        end
        instructions = w;
        instr_valid  = 1'b1;
        m_ret        = m_ret + 8'd1;
        e.acc        = e_acc;
        e.carry      = e_carry;
        e.zero       = (e_acc == 4'd0);
        e.ret        = m_ret;
        e.halted     = (w == 4'b1111);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk({tag, " ready low"}, 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        pop_cmp(tag);
        if (w != 4'b1111) chk({tag, " ready high"}, 32'(instr_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        instr_valid  = 1'b0;
        instructions = 4'd0;
        rst_n        = 1'b0;
        m_ret        = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'b0011, 4'd3,  1'b0};
        vecs[1]  = '{4'b0111, 4'd6,  1'b0};
        vecs[2]  = '{4'b0111, 4'd9,  1'b0};
        vecs[3]  = '{4'b0000, 4'd0,  1'b0};
        vecs[4]  = '{4'b1001, 4'd15, 1'b1};
        vecs[5]  = '{4'b0101, 4'd0,  1'b1};
        vecs[6]  = '{4'b0011, 4'd3,  1'b0};
        vecs[7]  = '{4'b1110, 4'd6,  1'b0};
        vecs[8]  = '{4'b1110, 4'd12, 1'b0};
        vecs[9]  = '{4'b1110, 4'd8,  1'b1};
        vecs[10] = '{4'b1101, 4'd7,  1'b1};
        vecs[11] = '{4'b1100, 4'd0,  1'b0};
        vecs[12] = '{4'b0111, 4'd3,  1'b0};
        vecs[13] = '{4'b1011, 4'd0,  1'b0};
        vecs[14] = '{4'b0010, 4'd2,  1'b0};
        vecs[15] = '{4'b1011, 4'd15, 1'b1};
        vecs[16] = '{4'b0111, 4'd2,  1'b1};
        vecs[17] = '{4'b1101, 4'd13, 1'b1};

        rst_n = 1'b0;
        do_reset();
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        chk_reset_vals("idle hold");

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].instr, vecs[i].acc, vecs[i].carry,
                 $sformatf("vec%0d", i));
        end

        // HALT with valid held high and a new word presented afterwards.
        instructions = 4'b1111;
        instr_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("halt ready low", 32'(instr_ready), 32'd0);
        chk("halt not yet", 32'(halted), 32'd0);
        instructions = 4'b0010;
        @(posedge clk);
        #1;
        chk("halt set", 32'(halted), 32'd1);
        chk("halt acc", 32'(acc), 32'd13);
        chk("halt carry", 32'(carry), 32'd1);
        chk("halt retired", 32'(retired), 32'd19);
        repeat (6) @(posedge clk);
        #1;
        chk("stop ready", 32'(instr_ready), 32'd0);
        chk("stop halted", 32'(halted), 32'd1);
        chk("stop acc", 32'(acc), 32'd13);
        chk("stop retired", 32'(retired), 32'd19);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async rst");
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        m_ret       = 8'd0;
        @(negedge clk);

        // Reset while an instruction is in EXEC drops it.
        instructions = 4'b0011;
        instr_valid  = 1'b1;
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk_reset_vals("mid exec rst");
        @(posedge clk);
        #1;
        chk("mid exec retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Counter wrap: 300 instructions from reset leave retired at 44.
        send(4'b0001, 4'd1, 1'b0, "wrap ldi");
        for (int i = 0; i < 299; i++) begin
            send(4'b0100, 4'd1, 1'b0, "wrap addi");
        end
        chk("wrap retired", 32'(retired), 32'd44);
        chk("wrap acc", 32'(acc), 32'd1);
        chk("wrap zero", 32'(zero), 32'd0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
